// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional cancel port enabled by defining MDU_CANCEL_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    // Low 64 bits of the extended-operand product are correct for both signednesses.
    function automatic logic [63:0] mul_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        ey = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;
    endfunction

    // Returns {remainder, quotient}; signed case works on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 instead of relying on tool behaviour.
    function automatic logic [63:0] div_op(input logic [31:0] n, input logic [31:0] d,
                                           input logic sgn);
        logic        neg_n;
        logic        neg_d;
        logic [31:0] un;
        logic [31:0] ud;
        logic [31:0] q;
        logic [31:0] r;
        neg_n = sgn & n[31];
        neg_d = sgn & d[31];
        un    = neg_n ? (32'd0 - n) : n;
        ud    = neg_d ? (32'd0 - d) : d;
        if (ud == 32'd0) ud = 32'd1;
        q = un / ud;
        r = un % ud;
        if (neg_n ^ neg_d) q = 32'd0 - q;
        if (neg_n)         r = 32'd0 - r;
        return {r, q};
    endfunction

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        phi_q;
    logic [31:0]        plo_q;
    logic               pwr_q;
    logic               cancel_w;
    logic [63:0]        prod_d;
    logic [63:0]        divr_d;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    always_comb begin
        prod_d = mul_op(a, b, op == OP_MULT);
        divr_d = div_op(a, b, op == OP_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !cancel_w) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                phi_q   <= prod_d[63:32];
                                plo_q   <= prod_d[31:0];
                                pwr_q   <= 1'b1;
                                cnt_q   <= CNT_W'(MULT_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                phi_q   <= divr_d[63:32];
                                plo_q   <= divr_d[31:0];
                                pwr_q   <= (b != 32'd0);
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        if (pwr_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (cancel tests built when MDU_CANCEL_EN is defined).
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
    endtask

    // Issues a mult/div and checks busy length plus final HI/LO.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n_exp,
                          input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        int n;
        issue(o, x, y);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_rise got %b want 1", name, busy);
        end
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            tick();
            if (busy === 1'b1) n++;
        end
        checks++;
        if (n !== n_exp) begin
            errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, n_exp);
        end
        checks++;
        if (hi !== hi_exp) begin
            errors++; $display("FAIL %s hi got %h want %h", name, hi, hi_exp);
        end
        checks++;
        if (lo !== lo_exp) begin
            errors++; $display("FAIL %s lo got %h want %h", name, lo, lo_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++;
        if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_mult();
        run_op("mult_neg", 3'd0, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_big", 3'd0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
    endtask

    task automatic test_div();
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run_op("divu_big", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'd1, 32'h7FFFFFFC);
    endtask

    task automatic test_move();
        issue(3'd4, 32'h12345678, 32'd0);
        checks++;
        if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
        issue(3'd5, 32'hCAFEF00D, 32'd0);
        checks++;
        if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo got %h want cafef00d", lo); end
        issue(3'd6, 32'h11111111, 32'd3);
        tick();
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D || busy !== 1'b0) begin
            errors++; $display("FAIL reserved_op got hi=%h lo=%h busy=%b want 12345678 cafef00d 0", hi, lo, busy);
        end
    endtask

    task automatic test_div_zero();
        run_op("div_zero", 3'd2, 32'd55, 32'd0, 10, 32'h12345678, 32'hCAFEF00D);
        run_op("divu_zero", 3'd3, 32'd55, 32'd0, 10, 32'h12345678, 32'hCAFEF00D);
    endtask

    // Starts while busy must be dropped entirely, including the busy count.
    task automatic test_back_to_back();
        issue(3'd1, 32'd3, 32'd4);
        tick();
        start = 1'b1; op = 3'd5; a = 32'h0000DEAD;
        tick();
        op = 3'd2; a = 32'd9; b = 32'd1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++; $display("FAIL start_while_busy got busy=%b hi=%h lo=%h want 0 0 c", busy, hi, lo);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || lo !== 32'd12) begin
            errors++; $display("FAIL no_second_op got busy=%b lo=%h want 0 c", busy, lo);
        end
    endtask

    task automatic test_reset_midflight();
        issue(3'd0, 32'hFFFFFFFF, 32'd2);
        tick();
        start = 1'b1; op = 3'd5; a = 32'h0000DEAD;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_midflight got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        repeat (6) tick();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL no_late_commit got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        issue(3'd4, 32'h00000AAA, 32'd0);
        issue(3'd5, 32'h00000BBB, 32'd0);
        issue(3'd3, 32'd100, 32'd3);
        repeat (5) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h00000AAA || lo !== 32'h00000BBB) begin
            errors++; $display("FAIL cancel_run got busy=%b hi=%h lo=%h want 0 aaa bbb", busy, hi, lo);
        end
        repeat (6) tick();
        checks++;
        if (hi !== 32'h00000AAA || lo !== 32'h00000BBB) begin
            errors++; $display("FAIL cancel_late got hi=%h lo=%h want aaa bbb", hi, lo);
        end
        cancel = 1'b1;
        issue(3'd0, 32'd5, 32'd5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start got busy=%b want 0", busy); end
        cancel = 1'b1;
        issue(3'd4, 32'h0000FFFF, 32'd0);
        cancel = 1'b0;
        checks++;
        if (hi !== 32'h00000AAA) begin errors++; $display("FAIL cancel_mthi got hi=%h want aaa", hi); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #2;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_div_zero();
        test_back_to_back();
        test_reset_midflight();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
